// File: rtl/sa_result_demux_collector_pkg.sv
// sa_pkg: shared systolic-array definitions; the row schedule is used by both the feed select and the result collector.
package sa_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  localparam int SA_DIM = 3;
  localparam int SA_STEPS = 9;
  // step -> row, entry s at bits [2*s +: 2]; rows fill in skewed order 0,0,1,0,1,2,1,2,2
  localparam logic [2*SA_STEPS-1:0] ROW_SCHED = {2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
  function automatic logic [1:0] row_of(input logic [3:0] step);
    return (int'(step) < SA_STEPS) ? ROW_SCHED[int'(step)*2 +: 2] : 2'd0;
  endfunction
endpackage

// File: rtl/sa_result_demux_collector_row_lut.sv
// sa_collect_row_lut: combinational schedule step to destination row lookup; out-of-range steps map to row 0.
module sa_collect_row_lut
  import sa_pkg::*;
(
  input  logic [3:0] i_step,
  output logic [1:0] o_row
);
  assign o_row = row_of(i_step);
endmodule

// File: rtl/sa_result_demux_collector.sv
// sa_result_demux_collector: steers the skewed 3x3 result lane into rows and presents the matrix via valid/ready.
// Optional sticky protocol-error flag enabled by defining SA_COLLECT_ERR_EN.
module sa_result_demux_collector
  import sa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CNT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [9*DATA_W-1:0]        out_data,
  output logic [3:0]                 cnt,
  output logic                       busy,
  output logic                       err
);
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_colptr [SA_DIM];
  logic [9*DATA_W-1:0] r_data;
  logic              r_out_valid;
  logic [1:0]        w_row;
  logic [1:0]        w_col;

  sa_collect_row_lut u_lut (.i_step(r_cnt), .o_row(w_row));

  assign w_col     = r_colptr[w_row];
  assign in_ready  = r_state == COLLECT;
  assign busy      = r_state != IDLE;
  assign cnt       = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_colptr    <= '{default: '0};
      r_data      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state  <= COLLECT;
          r_cnt    <= '0;
          r_colptr <= '{default: '0};
        end
        COLLECT: if (in_valid) begin
          r_data[(32'(w_row)*SA_DIM + 32'(w_col))*DATA_W +: DATA_W] <= in_data;
          r_colptr[w_row] <= w_col + 2'd1;
          r_cnt           <= (r_cnt == 4'(CNT_MAX)) ? 4'd0 : r_cnt + 4'd1;
          if (r_cnt == 4'(CNT_MAX)) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SA_COLLECT_ERR_EN
  logic r_err;
  // dropped beat outside COLLECT, or a restart request mid-collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if ((in_valid && r_state != COLLECT) || (start && r_state == COLLECT)) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
endmodule
